adc_sampler: RTL

ADC_SAMPLER -- requirements
Module: adc_sampler

---
 rtl/adc_pkg.sv | 32 +++
 rtl/spi_clk_div.sv | 39 +++
 rtl/adc_sampler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sampler: FSM states, frame geometry and
// the command bit pattern sent to the converter.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } adc_state_t;

    localparam int SHIFT_PERIODS     = 17;
    localparam int FIRST_DATA_PERIOD = 7;
    localparam int SAMPLE_W          = 10;
    localparam int PERIOD_W          = 5;
    localparam int CHAN_W            = 4;

    // Command bit for SCK period k: start, single-ended, channel MSB first, then zeros.
    function automatic logic cmd_bit(input logic [PERIOD_W-1:0] k, input logic [2:0] ch);
        logic b;
        case (k)
            5'd0, 5'd1: b = 1'b1;
            5'd2:       b = ch[2];
            5'd3:       b = ch[1];
            5'd4:       b = ch[0];
            default:    b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCK generator: counts CLK_DIV cycles per half-period while run is high and
// issues strobes one cycle ahead of each SCK edge.
module spi_clk_div #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic last,
    output logic sck,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             sck_reg;

    assign tick = run && (cnt_reg == CNT_W'(CLK_DIV - 1));
    // The final low half must not be followed by another rising edge.
    assign rise = tick && !sck_reg && !last;
    assign fall = tick && sck_reg;
    assign sck  = sck_reg;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt_reg <= '0;
            sck_reg <= 1'b0;
        end else if (tick) begin
            cnt_reg <= '0;
            sck_reg <= rise;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// Periodic single-ended conversion of one ADC channel over a mode-0 SPI link;
// each completed frame yields a one-cycle new_sample pulse.
module adc_sampler
    import adc_pkg::*;
#(
    parameter int CLK_DIV    = 8,
    parameter int GAP_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHAN_W-1:0]   channel,
    output logic                new_sample,
    output logic [SAMPLE_W-1:0] sample,
    output logic [CHAN_W-1:0]   sample_channel,
    output logic                spi_ss_n,
    output logic                spi_sck,
    output logic                spi_mosi,
    input  logic                spi_miso
);

    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    // DONE already counts as the first chip-select-high cycle of the gap.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    adc_state_t state_reg, state_next;

    logic [2:0]          ch_q_reg, ch_q_next;
    logic [PERIOD_W-1:0] period_reg, period_next;
    logic [GAP_W-1:0]    gap_reg, gap_next;
    logic [SAMPLE_W-1:0] shift_reg, shift_next;
    logic                ss_n_reg, ss_n_next;
    logic                mosi_reg, mosi_next;
    logic                new_sample_reg, new_sample_next;
    logic [SAMPLE_W-1:0] sample_reg, sample_next;
    logic [CHAN_W-1:0]   sample_channel_reg, sample_channel_next;

    logic                sck_run, sck_last, sck, sck_tick, sck_rise, sck_fall;
    logic [PERIOD_W-1:0] period_inc;
    logic [SHIFT_PERIODS:0] cmd_vec;

    assign sck_run    = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT);
    assign sck_last   = (state_reg == ST_SHIFT) && (period_reg == PERIOD_W'(SHIFT_PERIODS - 1));
    assign period_inc = period_reg + PERIOD_W'(1);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .run  (sck_run),
        .last (sck_last),
        .sck  (sck),
        .tick (sck_tick),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    // Full command table for the latched channel; entry SHIFT_PERIODS pads to zero.
    for (genvar gi = 0; gi <= SHIFT_PERIODS; gi++) begin : g_cmd
        assign cmd_vec[gi] = cmd_bit(PERIOD_W'(gi), ch_q_reg);
    end

    always_comb begin
        state_next          = state_reg;
        ch_q_next           = ch_q_reg;
        period_next         = period_reg;
        gap_next            = gap_reg;
        shift_next          = shift_reg;
        ss_n_next           = ss_n_reg;
        mosi_next           = mosi_reg;
        new_sample_next     = 1'b0;
        sample_next         = sample_reg;
        sample_channel_next = sample_channel_reg;

        case (state_reg)
            ST_IDLE: begin
                if (!channel[3]) begin
                    ch_q_next   = channel[2:0];
                    ss_n_next   = 1'b0;
                    mosi_next   = 1'b1;
                    period_next = '0;
                    shift_next  = '0;
                    state_next  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (sck_rise) begin
                    period_next = '0;
                    state_next  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sck_rise) begin
                    period_next = period_inc;
                    if (period_inc >= PERIOD_W'(FIRST_DATA_PERIOD))
                        shift_next = {shift_reg[SAMPLE_W-2:0], spi_miso};
                end
                if (sck_fall)
                    mosi_next = cmd_vec[period_inc];
                // End of the low half of the last period closes the frame.
                if (sck_tick && !sck && sck_last) begin
                    ss_n_next           = 1'b1;
                    mosi_next           = 1'b0;
                    new_sample_next     = 1'b1;
                    sample_next         = shift_reg;
                    sample_channel_next = {1'b0, ch_q_reg};
                    state_next          = ST_DONE;
                end
            end
            ST_DONE: begin
                gap_next   = '0;
                state_next = (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_reg == GAP_LAST)
                    state_next = ST_IDLE;
                else
                    gap_next = gap_reg + GAP_W'(1);
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            ch_q_reg           <= '0;
            period_reg         <= '0;
            gap_reg            <= '0;
            shift_reg          <= '0;
            ss_n_reg           <= 1'b1;
            mosi_reg           <= 1'b0;
            new_sample_reg     <= 1'b0;
            sample_reg         <= '0;
            sample_channel_reg <= '0;
        end else begin
            state_reg          <= state_next;
            ch_q_reg           <= ch_q_next;
            period_reg         <= period_next;
            gap_reg            <= gap_next;
            shift_reg          <= shift_next;
            ss_n_reg           <= ss_n_next;
            mosi_reg           <= mosi_next;
            new_sample_reg     <= new_sample_next;
            sample_reg         <= sample_next;
            sample_channel_reg <= sample_channel_next;
        end
    end

    assign new_sample     = new_sample_reg;
    assign sample         = sample_reg;
    assign sample_channel = sample_channel_reg;
    assign spi_ss_n       = ss_n_reg;
    assign spi_sck        = sck;
    assign spi_mosi       = mosi_reg;

endmodule
